multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-004 op  in  6  instruction opcode, Instr[31:26].
REQ-005 funct  in  6  R-type function field, Instr[5:0].
REQ-006 zero  in  1  ALU zero flag from datapath.
REQ-007 mem_ready  in  1  memory handshake: access completes in this cycle.
REQ-008 pcen  out  1  PC register write enable.
REQ-009 iord / irwrite / memwrite  out  1 each  address select (1 = ALUOut) / IR load / data store.
REQ-010 regwrite / regdst / memtoreg / alusrca  out  1 each  register-file controls and ALU A select (1 = reg A).
REQ-011 alusrcb  out  2  00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
REQ-012 pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-013 alucontrol  out  3  add 010, sub 110, and 000, or 001, slt 111.
REQ-014 illegal_op  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-015 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-016 FETCH:
- iord = 0, alusrca = 0, alusrcb = 01, aluop = add, pcsrc = 00.
- Stall while mem_ready = 0.
- When mem_ready = 1: irwrite = 1 and pcen = 1 in that cycle, then go to DECODE.
REQ-017 DECODE: alusrcb = 11, aluop = add. Next state by op:
- 0x23 or 0x2B -> MEMADR
- 0x00 -> EXECUTE
- 0x04 or 0x05 -> BRANCH
- 0x08 -> ADDIEXEC
- 0x02 -> JUMP
- any other op -> FETCH, with illegal_op = 1 for exactly that cycle.
REQ-018 MEMADR: alusrca = 1, alusrcb = 10, add; go to MEMRD if op = 0x23, else MEMWR.
REQ-019 MEMRD: iord = 1; hold until mem_ready = 1, then go to MEMWB.
REQ-020 MEMWR: iord = 1, memwrite = 1 while waiting; leave for FETCH on the cycle mem_ready = 1.
REQ-021 MEMWB: regdst = 0, memtoreg = 1, regwrite = 1; go to FETCH.
REQ-022 EXECUTE: alusrca = 1, alusrcb = 00, aluop = funct; go to ALUWB.
REQ-023 ALUWB: regdst = 1, memtoreg = 0, regwrite = 1; go to FETCH.
REQ-024 BRANCH: alusrca = 1, alusrcb = 00, sub, pcsrc = 01.
- pcen = zero for op 0x04; pcen = ~zero for op 0x05.
- Go to FETCH.
REQ-025 ADDIEXEC: alusrca = 1, alusrcb = 10, add; go to ADDIWB.
REQ-026 ADDIWB: regdst = 0, memtoreg = 0, regwrite = 1; go to FETCH.
REQ-027 JUMP: pcsrc = 10, pcen = 1; go to FETCH.
REQ-028 Any signal not listed for a state is 0 in that state. All outputs are combinational from state, op, funct, zero and mem_ready.
REQ-029 alucontrol:
- aluop add -> 010; aluop sub -> 110.
- aluop funct: 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111, other funct -> 010.
REQ-030 Latency with mem_ready tied to 1, in cycles from FETCH entry: R-type 4, lw 5, sw 4, beq/bne 3, addi 4, j 3.
REQ-031 pcen and a register write never assert in the same cycle. memwrite only asserts in MEMWR.

Reset
REQ-032 reset = 0 forces state to FETCH asynchronously.
REQ-033 While reset = 0, pcen, irwrite, memwrite, regwrite and illegal_op are all 0, regardless of mem_ready.
REQ-034 On the first rising edge after reset deasserts, the FSM acts as FETCH. Reset mid-instruction abandons the instruction and performs no writeback.

Structure
REQ-035 The shared package holds:
- the state enum
- the opcode and funct constants
- the aluop enum (add, sub, funct)
- the alusrcb and pcsrc encodings.
It reuses the existing u1 and u32 typedefs.
REQ-036 One sub-module, alu_decoder (aluop, funct -> alucontrol), instantiated once. The FSM stays in multicycle_ctrl.

Verification
REQ-037 Drive op 0x08 with mem_ready = 1 -> state sequence FETCH, DECODE, ADDIEXEC, ADDIWB; regwrite = 1 only in the 4th cycle, with regdst = 0.
REQ-038 Drive op 0x00, funct 0x2A -> alucontrol = 111 in EXECUTE; ALUWB has regdst = 1 and regwrite = 1.
REQ-039 Drive op 0x04 with zero = 1, then with zero = 0 -> pcen = 1 in BRANCH for the first case, 0 for the second; op 0x05 gives the inverse.
REQ-040 Hold mem_ready = 0 for 3 cycles in FETCH, then 1 -> irwrite and pcen stay 0 for those 3 cycles and pulse 1 in the 4th; DECODE follows.
REQ-041 Drive op 0x3F -> illegal_op = 1 for one DECODE cycle, next state FETCH, no write enables asserted.
REQ-042 Assert reset = 0 asynchronously during MEMRD of op 0x23 -> write enables drop to 0 immediately, no MEMWB occurs, and FETCH is active after release.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared types and encodings for the multicycle MIPS controller:
//               FSM states, opcode/funct constants, ALU-op classes and the
//               ALU-B / PC-source mux encodings.
// Revision    : 1.0 - initial release
//==============================================================================
package multicycle_ctrl_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    // ALU operation class handed to the ALU decoder; ADD is the all-zero idle value
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type function codes (Instr[5:0])
    localparam logic [5:0] c_FUNCT_ADD = 6'h20;
    localparam logic [5:0] c_FUNCT_SUB = 6'h22;
    localparam logic [5:0] c_FUNCT_AND = 6'h24;
    localparam logic [5:0] c_FUNCT_OR  = 6'h25;
    localparam logic [5:0] c_FUNCT_SLT = 6'h2A;

    // ALU control codes
    localparam logic [2:0] c_ALUCTL_AND = 3'b000;
    localparam logic [2:0] c_ALUCTL_OR  = 3'b001;
    localparam logic [2:0] c_ALUCTL_ADD = 3'b010;
    localparam logic [2:0] c_ALUCTL_SUB = 3'b110;
    localparam logic [2:0] c_ALUCTL_SLT = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] c_SRCB_REG    = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH2 = 2'b11;

    // PC source select
    localparam logic [1:0] c_PCSRC_ALURES = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module      : multicycle_ctrl_if
// Description : Bundle between the multicycle controller and its datapath.
//               master = controller side, slave = datapath side.
// Revision    : 1.0 - initial release
//==============================================================================
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    // Datapath status into the controller
    logic [5:0] op;
    logic [5:0] funct;
    u1          zero;
    u1          mem_ready;

    // Controls out of the controller
    u1          pcen;
    u1          iord;
    u1          irwrite;
    u1          memwrite;
    u1          regwrite;
    u1          regdst;
    u1          memtoreg;
    u1          alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    u1          illegal_op;

    modport master (
        input  op, funct, zero, mem_ready,
        output pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcen, iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, illegal_op
    );

endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_alu_decoder.sv
`default_nettype none
//==============================================================================
// Module      : alu_decoder
// Description : Maps the controller's ALU-op class plus the R-type funct field
//               onto the 3-bit ALU control code.
// Revision    : 1.0 - initial release
//==============================================================================
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  aluop_e     aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    // Fixed add/sub for address and branch work; funct selects for R-type
    always_comb begin
        alucontrol_o = c_ALUCTL_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = c_ALUCTL_ADD;
            ALUOP_SUB: alucontrol_o = c_ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    c_FUNCT_ADD: alucontrol_o = c_ALUCTL_ADD;
                    c_FUNCT_SUB: alucontrol_o = c_ALUCTL_SUB;
                    c_FUNCT_AND: alucontrol_o = c_ALUCTL_AND;
                    c_FUNCT_OR:  alucontrol_o = c_ALUCTL_OR;
                    c_FUNCT_SLT: alucontrol_o = c_ALUCTL_SLT;
                    default:     alucontrol_o = c_ALUCTL_ADD;
                endcase
            end
            default: alucontrol_o = c_ALUCTL_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : multicycle_ctrl
// Description : Multicycle MIPS main controller. Two-process FSM; every
//               control output is combinational from state and inputs.
//               Write enables are gated by reset so nothing commits while the
//               controller is held in reset.
// Revision    : 1.0 - initial release
//==============================================================================
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,   // asynchronous, active-low
    multicycle_ctrl_if.master   bus
);

    state_e     state_q;
    state_e     state_d;

    aluop_e     w_aluop;
    logic [2:0] w_alucontrol;
    u1          w_pcen;
    u1          w_iord;
    u1          w_irwrite;
    u1          w_memwrite;
    u1          w_regwrite;
    u1          w_regdst;
    u1          w_memtoreg;
    u1          w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    u1          w_illegal;

    // State register; reset returns to FETCH without waiting for a clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; everything defaults to zero / add
    always_comb begin
        state_d    = state_q;
        w_aluop    = ALUOP_ADD;
        w_pcen     = 1'b0;
        w_iord     = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = c_SRCB_REG;
        w_pcsrc    = c_PCSRC_ALURES;
        w_illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 computed every cycle, only committed with the IR load
                w_alusrcb = c_SRCB_FOUR;
                if (bus.mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcen    = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                w_alusrcb = c_SRCB_IMMSH2;
                case (bus.op)
                    c_OP_LW, c_OP_SW:   state_d = S_MEMADR;
                    c_OP_RTYPE:         state_d = S_EXECUTE;
                    c_OP_BEQ, c_OP_BNE: state_d = S_BRANCH;
                    c_OP_ADDI:          state_d = S_ADDIEXEC;
                    c_OP_J:             state_d = S_JUMP;
                    default: begin
                        w_illegal = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = c_SRCB_IMM;
                state_d   = (bus.op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWR: begin
                // Store is presented until memory accepts it
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                // beq takes on equal, bne on not-equal
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_SUB;
                w_pcsrc   = c_PCSRC_ALUOUT;
                w_pcen    = (bus.op == c_OP_BEQ) ? bus.zero : ~bus.zero;
                state_d   = S_FETCH;
            end
            S_ADDIEXEC: begin
                w_alusrca = 1'b1;
                w_alusrcb = c_SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                w_pcsrc = c_PCSRC_JUMP;
                w_pcen  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop_i      (w_aluop),
        .funct_i      (bus.funct),
        .alucontrol_o (w_alucontrol)
    );

    // Commit-type outputs are forced low while reset is asserted
    assign bus.pcen       = w_pcen     & reset;
    assign bus.irwrite    = w_irwrite  & reset;
    assign bus.memwrite   = w_memwrite & reset;
    assign bus.regwrite   = w_regwrite & reset;
    assign bus.illegal_op = w_illegal  & reset;

    assign bus.iord       = w_iord;
    assign bus.regdst     = w_regdst;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.alucontrol = w_alucontrol;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. An instruction-level
//               model describes each instruction as its list of cycles and
//               the controls expected in each; directed and random
//               instructions are compared cycle by cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   stall_left = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed control word
    wire [15:0] w_obs = {bus.pcen, bus.iord, bus.irwrite, bus.memwrite,
                         bus.regwrite, bus.regdst, bus.memtoreg, bus.alusrca,
                         bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal_op};

    // Build an expected control word from named fields
    function automatic logic [15:0] mk(input logic pcen, input logic iord,
                                       input logic irw, input logic memw,
                                       input logic regw, input logic regdst,
                                       input logic m2r, input logic asa,
                                       input logic [1:0] srcb, input logic [1:0] pcs,
                                       input logic [2:0] aluc, input logic ill);
        return {pcen, iord, irw, memw, regw, regdst, m2r, asa, srcb, pcs, aluc, ill};
    endfunction

    // ALU control table for R-type instructions
    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return (o == 6'h00) || (o == 6'h02) || (o == 6'h04) || (o == 6'h05) ||
               (o == 6'h08) || (o == 6'h23) || (o == 6'h2B);
    endfunction

    // mem_ready for a cycle where memory completion matters
    function automatic logic wait_mr(input bit rnd);
        if (rnd) return ($urandom_range(0, 3) != 0);
        if (stall_left > 0) begin
            stall_left--;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // mem_ready for a cycle where it should be ignored
    function automatic logic any_mr(input bit rnd);
        return rnd ? logic'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic check(input string tag, input logic [15:0] expv);
        total++;
        assert (w_obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, w_obs, expv);
        end
    endtask

    // One clock cycle: drive mem_ready, compare mid-cycle, advance past the edge
    task automatic step(input logic mr, input string tag, input logic [15:0] expv);
        bus.mem_ready = mr;
        #2;
        check(tag, expv);
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH entry to its return to FETCH
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input logic z, input bit rnd);
        logic mr;
        bus.op    = o;
        bus.funct = f;
        bus.zero  = z;
        for (int i = 0; i < 16; i++) begin
            mr = (i >= 8) ? 1'b1 : wait_mr(rnd);
            step(mr, "fetch", mk(mr, 0, mr, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
            if (mr) break;
        end
        step(any_mr(rnd), "decode",
             mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, !is_legal(o)));
        if (!is_legal(o)) return;
        case (o)
            6'h23, 6'h2B: begin
                step(any_mr(rnd), "memadr",
                     mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
                for (int i = 0; i < 16; i++) begin
                    mr = (i >= 8) ? 1'b1 : wait_mr(rnd);
                    if (o == 6'h23)
                        step(mr, "memrd", mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
                    else
                        step(mr, "memwr", mk(0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
                    if (mr) break;
                end
                if (o == 6'h23)
                    step(any_mr(rnd), "memwb",
                         mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 0));
            end
            6'h00: begin
                step(any_mr(rnd), "execute",
                     mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ref_alu(f), 0));
                step(any_mr(rnd), "aluwb",
                     mk(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0));
            end
            6'h04, 6'h05: begin
                step(any_mr(rnd), "branch",
                     mk((o == 6'h04) ? z : !z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0));
            end
            6'h08: begin
                step(any_mr(rnd), "addiexec",
                     mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
                step(any_mr(rnd), "addiwb",
                     mk(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
            end
            default: begin
                step(any_mr(rnd), "jump",
                     mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 0));
            end
        endcase
    endtask

    // Outputs while held in reset: FETCH controls with all commits suppressed
    localparam logic [15:0] c_RST_VEC = 16'b0000_0000_01_00_010_0;

    initial begin
        #20000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] o;
        logic [5:0] f;
        logic [5:0] fl [6];
        logic [5:0] ol [7];
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
        ol = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};

        // Reset held: no commits whatever mem_ready does
        reset         = 1'b0;
        bus.op        = 6'h00;
        bus.funct     = 6'h20;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        check("reset_mr1", c_RST_VEC);
        bus.mem_ready = 1'b0;
        #1;
        check("reset_mr0", c_RST_VEC);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        #1;
        check("reset_hold", c_RST_VEC);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // addi, slt, branches taken / not taken
        run_instr(6'h08, 6'h00, 1'b0, 1'b0);
        run_instr(6'h00, 6'h2A, 1'b0, 1'b0);
        run_instr(6'h04, 6'h00, 1'b1, 1'b0);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0);
        run_instr(6'h05, 6'h00, 1'b1, 1'b0);
        run_instr(6'h05, 6'h00, 1'b0, 1'b0);

        // Three-cycle fetch stall before a jump
        stall_left = 3;
        run_instr(6'h02, 6'h00, 1'b0, 1'b0);

        // Unsupported opcode
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0);

        // Loads / stores with and without memory stalls
        run_instr(6'h23, 6'h00, 1'b0, 1'b0);
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0);
        stall_left = 0;
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0);
        stall_left = 1;
        run_instr(6'h23, 6'h00, 1'b0, 1'b0);
        stall_left = 2;
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0);

        // Reset during a load read: no writeback, FETCH after release
        bus.op = 6'h23;
        step(1'b1, "lw_fetch", mk(1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0));
        step(1'b1, "lw_decode", mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0));
        step(1'b1, "lw_memadr", mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0));
        bus.mem_ready = 1'b1;
        #1;
        check("lw_memrd", mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0));
        reset = 1'b0;
        #1;
        check("rst_async", c_RST_VEC);
        @(posedge clk);
        #1;
        check("rst_no_memwb", c_RST_VEC);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr(6'h00, 6'h25, 1'b0, 1'b0);

        // Random instruction mix with random memory timing
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 7) begin
                o = 6'($urandom_range(0, 63));
                while (is_legal(o)) o = 6'($urandom_range(0, 63));
            end else begin
                o = ol[$urandom_range(0, 6)];
            end
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                            : fl[$urandom_range(0, 5)];
            run_instr(o, f, logic'($urandom_range(0, 1)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
